// File: rtl/led_arbiter.sv
// LED ownership arbiter: heartbeat walking-one, HPS pattern passthrough, and a
// latched fault-code blink display sharing the 8 green LEDs (FAULT > HPS > HB).
module led_arbiter #(
  parameter int unsigned TICK_DIV    = 5000000,
  parameter int unsigned HOLD_TICKS  = 10,
  parameter int unsigned BLINK_TICKS = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       hps_req,
  input  logic [7:0] hps_leds,
  input  logic       fault_req,
  input  logic [3:0] fault_code,
  input  logic       fault_clr,
  output logic [7:0] leds,
  output logic [2:0] grant,
  output logic       fault_ack
);

  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic [1:0] {
    ST_HB    = 2'd0,
    ST_HPS   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [BW-1:0]  blink_q, blink_d;
  logic           phase_q, phase_d;
  logic [3:0]     code_q, code_d;
  logic [7:0]     walk_q, walk_d;
  logic [7:0]     leds_q, leds_d;
  logic           ack_q, ack_d;
  logic           tick_c;

  // Display tick: one cycle per TICK_DIV clocks, independent of state.
  assign tick_c = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Owner decode straight from the state register.
  always_comb begin
    grant = 3'b001;
    case (state_q)
      ST_HPS:   grant = 3'b010;
      ST_FAULT: grant = 3'b100;
      default:  grant = 3'b001;
    endcase
  end

  assign leds      = leds_q;
  assign fault_ack = ack_q;

  // Next-state and datapath next values.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
    hold_d     = hold_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    code_d     = code_q;
    walk_d     = walk_q;
    leds_d     = walk_q;
    ack_d      = 1'b0;

    case (state_q)
      ST_HB: begin
        leds_d = walk_q;
        if (tick_c) walk_d = {walk_q[6:0], walk_q[7]};
        if (fault_req) begin
          state_d = ST_FAULT;
          code_d  = fault_code;
          phase_d = 1'b1;
          blink_d = '0;
          ack_d   = 1'b1;
        end else if (hps_req) begin
          state_d = ST_HPS;
          hold_d  = '0;
        end
      end
      ST_HPS: begin
        leds_d = hps_leds;
        if (tick_c && (hold_q != HW'(HOLD_TICKS))) hold_d = hold_q + HW'(1);
        if (fault_req) begin
          state_d = ST_FAULT;
          code_d  = fault_code;
          phase_d = 1'b1;
          blink_d = '0;
          ack_d   = 1'b1;
        end else if (!hps_req && (hold_q == HW'(HOLD_TICKS))) begin
          state_d = ST_HB;
        end
      end
      ST_FAULT: begin
        leds_d = {code_q, phase_q ? 4'hF : 4'h0};
        if (tick_c) begin
          if (blink_q == BW'(BLINK_TICKS - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
        if (fault_clr && !fault_req) state_d = ST_HB;
      end
      default: state_d = ST_HB;
    endcase
  end

  // All state, async active-high reset.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= ST_HB;
      tick_cnt_q <= '0;
      hold_q     <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b0;
      code_q     <= 4'h0;
      walk_q     <= 8'h01;
      leds_q     <= 8'h00;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      code_q     <= code_d;
      walk_q     <= walk_d;
      leds_q     <= leds_d;
      ack_q      <= ack_d;
    end
  end

endmodule
